// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller.
//   - opcode constants (OP_LOADI..OP_OR)
//   - ALU_SELECT codes (SEL_FWD/ADD/AND/OR)
//   - instruction field bit positions
//   - controller state encoding
//   - is_legal_op(): opcode legality check
package alu_pkg;

  localparam int INSTR_W = 32;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 3;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 4;

  // Instruction field positions
  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 24;
  localparam int DEST_MSB = 18;
  localparam int DEST_LSB = 16;
  localparam int SRC1_MSB = 10;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_MSB = 2;
  localparam int SRC2_LSB = 0;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  // Opcodes; anything above OP_OR is illegal
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  // ALU function select codes
  localparam logic [SEL_W-1:0] SEL_FWD = 3'b000;
  localparam logic [SEL_W-1:0] SEL_ADD = 3'b001;
  localparam logic [SEL_W-1:0] SEL_AND = 3'b010;
  localparam logic [SEL_W-1:0] SEL_OR  = 3'b011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op <= OP_OR);
  endfunction

endpackage

// File: rtl/reg_file_8x8.sv
// 8-entry x 8-bit register file.
// Ports:
//   clk, rst_n            clock, asynchronous active-low clear of all entries
//   rd_addr_a/rd_data_a   async read port A
//   rd_addr_b/rd_data_b   async read port B
//   dbg_addr/dbg_data     async debug read port
//   we/wr_addr/wr_data    synchronous write port
// Reads return the stored value only; a write becomes visible after its edge.
module reg_file_8x8
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [8];
  logic [DATA_W-1:0] mem_d [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];
  assign dbg_data  = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the 8-bit ALU interface.
// Accepts one instruction at a time, reads operands from the internal register
// file, drives registered DATA1/DATA2/SELECT to an external combinational ALU,
// waits ALU_WAIT extra cycles, then writes ALU_RESULT back to REG[dest].
// Ports:
//   CLK, RESET_N              clock, asynchronous active-low reset
//   INSTR, INSTR_VALID        instruction input; [31:24] op, [18:16] dest,
//                             [10:8] src1, [2:0] src2 / [7:0] imm
//   INSTR_READY               high iff the controller is IDLE
//   ALU_DATA1/2, ALU_SELECT   registered ALU operands and function
//   ALU_RESULT                ALU output, written back at end of EXEC
//   DONE                      one-cycle pulse after a writeback edge
//   ERROR                     one-cycle pulse after an illegal opcode is rejected
//   DBG_ADDR, DBG_DATA        combinational debug read of the register file
// Handshake: an instruction transfers on a rising edge where INSTR_VALID and
// INSTR_READY are both high; INSTR must be held stable while VALID waits for
// READY. READY is a pure function of state, never of VALID.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_WAIT = 1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  output logic [DATA_W-1:0]  ALU_DATA1,
  output logic [DATA_W-1:0]  ALU_DATA2,
  output logic [SEL_W-1:0]   ALU_SELECT,
  input  logic [DATA_W-1:0]  ALU_RESULT,
  output logic               DONE,
  output logic               ERROR,
  input  logic [ADDR_W-1:0]  DBG_ADDR,
  output logic [DATA_W-1:0]  DBG_DATA
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(ALU_WAIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // Instruction fields
  logic [7:0]        op;
  logic [ADDR_W-1:0] dest_f;
  logic [ADDR_W-1:0] src1_f;
  logic [ADDR_W-1:0] src2_f;
  logic [DATA_W-1:0] imm_f;
  logic              unused_instr_bits;

  assign op     = INSTR[OP_MSB:OP_LSB];
  assign dest_f = INSTR[DEST_MSB:DEST_LSB];
  assign src1_f = INSTR[SRC1_MSB:SRC1_LSB];
  assign src2_f = INSTR[SRC2_MSB:SRC2_LSB];
  assign imm_f  = INSTR[IMM_MSB:IMM_LSB];
  assign unused_instr_bits = ^{INSTR[23:19], INSTR[15:11]};

  // Register file
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              wr_en;

  reg_file_8x8 u_regs (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .rd_addr_a (src1_f),
    .rd_data_a (rd_a),
    .rd_addr_b (src2_f),
    .rd_data_b (rd_b),
    .dbg_addr  (DBG_ADDR),
    .dbg_data  (DBG_DATA),
    .we        (wr_en),
    .wr_addr   (dest_q),
    .wr_data   (ALU_RESULT)
  );

  // Operand mux for the instruction currently presented on INSTR
  logic [DATA_W-1:0] op_d1, op_d2;
  logic [SEL_W-1:0]  op_sel;

  always_comb begin
    op_d1  = '0;
    op_d2  = '0;
    op_sel = SEL_FWD;
    case (op)
      OP_LOADI: begin
        op_d2 = imm_f;
      end
      OP_MOV: begin
        op_d2 = rd_b;
      end
      OP_ADD: begin
        op_d1  = rd_a;
        op_d2  = rd_b;
        op_sel = SEL_ADD;
      end
      OP_SUB: begin
        // Two's complement of src2 turns the adder into a subtractor
        op_d1  = rd_a;
        op_d2  = ~rd_b + 8'd1;
        op_sel = SEL_ADD;
      end
      OP_AND: begin
        op_d1  = rd_a;
        op_d2  = rd_b;
        op_sel = SEL_AND;
      end
      OP_OR: begin
        op_d1  = rd_a;
        op_d2  = rd_b;
        op_sel = SEL_OR;
      end
      default: begin
        op_d1  = '0;
        op_d2  = '0;
        op_sel = SEL_FWD;
      end
    endcase
  end

  // Next-state / output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    data1_d = data1_q;
    data2_d = data2_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (INSTR_VALID) begin
          if (is_legal_op(op)) begin
            dest_d  = dest_f;
            data1_d = op_d1;
            data2_d = op_d2;
            sel_d   = op_sel;
            cnt_d   = WAIT_INIT;
            state_d = ST_EXEC;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          wr_en   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
      data1_q <= '0;
      data2_q <= '0;
      sel_q   <= SEL_FWD;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign INSTR_READY = (state_q == ST_IDLE);
  assign ALU_DATA1   = data1_q;
  assign ALU_DATA2   = data2_q;
  assign ALU_SELECT  = sel_q;
  assign DONE        = done_q;
  assign ERROR       = error_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  alu_data1;
  logic [7:0]  alu_data2;
  logic [2:0]  alu_select;
  logic [7:0]  alu_result;
  logic        done;
  logic        error;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #4 clk = ~clk;

  alu_issue_ctrl #(.ALU_WAIT(1)) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .INSTR       (instr),
    .INSTR_VALID (instr_valid),
    .INSTR_READY (instr_ready),
    .ALU_DATA1   (alu_data1),
    .ALU_DATA2   (alu_data2),
    .ALU_SELECT  (alu_select),
    .ALU_RESULT  (alu_result),
    .DONE        (done),
    .ERROR       (error),
    .DBG_ADDR    (dbg_addr),
    .DBG_DATA    (dbg_data)
  );

  // Combinational ALU: forward passes DATA2
  always_comb begin
    alu_result = 8'h00;
    case (alu_select)
      3'b000:  alu_result = alu_data2;
      3'b001:  alu_result = alu_data1 + alu_data2;
      3'b010:  alu_result = alu_data1 & alu_data2;
      3'b011:  alu_result = alu_data1 | alu_data2;
      default: alu_result = 8'h00;
    endcase
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [2:0] dst,
                                     input logic [2:0] s1, input logic [7:0] s2);
    return {op, 5'b0, dst, 5'b0, s1, s2};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic read_reg(input logic [2:0] a, output logic [7:0] v);
    @(negedge clk);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    read_reg(a, v);
    check_eq(tag, {24'b0, v}, {24'b0, exp});
  endtask

  // Issue one instruction and wait for DONE; checks latency, EXEC select and writeback
  task automatic do_instr(input string tag, input logic [31:0] ins, input logic [2:0] exp_sel,
                          input logic [2:0] dst, input logic [7:0] exp_val);
    int n;
    bit got;
    logic [2:0] sel_seen;
    @(negedge clk);
    check_eq({tag, "_ready"}, {31'b0, instr_ready}, 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    n = 0;
    got = 1'b0;
    sel_seen = 3'b111;
    while (n < 10 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) sel_seen = alu_select;
      if (done) got = 1'b1;
    end
    check_eq({tag, "_done_lat"}, n, 3);
    check_eq({tag, "_sel"}, {29'b0, sel_seen}, {29'b0, exp_sel});
    check_reg({tag, "_wb"}, dst, exp_val);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] exp_regs [8];
    logic [7:0] v;
    logic [31:0] iq [4];
    int k, cyc, last, dcount;
    bit rdy;

    rst_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    dbg_addr = '0;

    // Reset state
    #3;
    check_eq("rst_ready", {31'b0, instr_ready}, 32'd1);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_error", {31'b0, error}, 32'd0);
    check_eq("rst_d1", {24'b0, alu_data1}, 32'h0);
    check_eq("rst_d2", {24'b0, alu_data2}, 32'h0);
    check_eq("rst_sel", {29'b0, alu_select}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Reset mid-EXEC of LOADI r1,0x55
    @(negedge clk);
    instr = mk(8'h00, 3'd1, 3'd0, 8'h55);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_exec_busy", {31'b0, instr_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("t1_ready_in_rst", {31'b0, instr_ready}, 32'd1);
    dcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcount++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check_eq("t1_no_done", dcount, 0);
    check_reg("t1_r1", 3'd1, 8'h00);

    // 2. LOADI / ADD
    do_instr("t2_ld1", mk(8'h00, 3'd1, 3'd0, 8'h05), 3'b000, 3'd1, 8'h05);
    do_instr("t2_ld2", mk(8'h00, 3'd2, 3'd0, 8'h03), 3'b000, 3'd2, 8'h03);
    do_instr("t2_add", mk(8'h02, 3'd3, 3'd1, 8'h02), 3'b001, 3'd3, 8'h08);

    // 3. SUB and wrapping ADD
    do_instr("t3_sub", mk(8'h03, 3'd4, 3'd2, 8'h01), 3'b001, 3'd4, 8'hFE);
    do_instr("t3_ldff", mk(8'h00, 3'd1, 3'd0, 8'hFF), 3'b000, 3'd1, 8'hFF);
    do_instr("t3_addw", mk(8'h02, 3'd5, 3'd1, 8'h01), 3'b001, 3'd5, 8'hFE);

    // 4. AND / OR / MOV
    do_instr("t4_ld1", mk(8'h00, 3'd1, 3'd0, 8'hD5), 3'b000, 3'd1, 8'hD5);
    do_instr("t4_ld2", mk(8'h00, 3'd2, 3'd0, 8'hEA), 3'b000, 3'd2, 8'hEA);
    do_instr("t4_and", mk(8'h04, 3'd6, 3'd1, 8'h02), 3'b010, 3'd6, 8'hC0);
    do_instr("t4_or",  mk(8'h05, 3'd7, 3'd1, 8'h02), 3'b011, 3'd7, 8'hFF);
    do_instr("t4_mov", mk(8'h01, 3'd0, 3'd0, 8'h07), 3'b000, 3'd0, 8'hFF);

    // 5. Illegal opcode
    exp_regs[0] = 8'hFF; exp_regs[1] = 8'hD5; exp_regs[2] = 8'hEA; exp_regs[3] = 8'h08;
    exp_regs[4] = 8'hFE; exp_regs[5] = 8'hFE; exp_regs[6] = 8'hC0; exp_regs[7] = 8'hFF;
    @(negedge clk);
    instr = mk(8'h09, 3'd3, 3'd1, 8'h02);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check_eq("t5_error", {31'b0, error}, 32'd1);
    check_eq("t5_no_done", {31'b0, done}, 32'd0);
    check_eq("t5_ready", {31'b0, instr_ready}, 32'd1);
    check_eq("t5_sel_held", {29'b0, alu_select}, 32'h0);
    @(negedge clk);
    check_eq("t5_error_pulse", {31'b0, error}, 32'd0);
    check_eq("t5_no_done2", {31'b0, done}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check_reg($sformatf("t5_r%0d", i), 3'(i), exp_regs[i]);
    end

    // 6. VALID held high with four queued instructions
    iq[0] = mk(8'h00, 3'd1, 3'd0, 8'h02);
    iq[1] = mk(8'h02, 3'd1, 3'd1, 8'h01);
    iq[2] = mk(8'h02, 3'd1, 3'd1, 8'h01);
    iq[3] = mk(8'h01, 3'd2, 3'd0, 8'h01);
    exp_q.push_back(8'h08);  // r1
    exp_q.push_back(8'h08);  // r2
    k = 0;
    cyc = 0;
    last = 0;
    @(negedge clk);
    instr = iq[0];
    instr_valid = 1'b1;
    while (k < 4 && cyc < 60) begin
      rdy = instr_ready;
      @(posedge clk);
      cyc++;
      #1;
      if (rdy) begin
        if (k > 0) check_eq($sformatf("t6_spacing%0d", k), cyc - last, 3);
        last = cyc;
        k++;
        if (k < 4) instr = iq[k];
        else instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("t6_accepts", k, 4);
    dcount = 0;
    cyc = 0;
    while (dcount == 0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (done) dcount++;
    end
    check_eq("t6_last_done", dcount, 1);
    read_reg(3'd1, v);
    check_eq("t6_r1", {24'b0, v}, {24'b0, exp_q.pop_front()});
    read_reg(3'd2, v);
    check_eq("t6_r2", {24'b0, v}, {24'b0, exp_q.pop_front()});

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
